// File: rtl/regfile_wb.sv
// regfile_wb: write-back funnel and pending-write scoreboard.
//
// Merges two result streams (ALU and load) onto the single register file
// write port with round-robin arbitration, and tracks which architectural
// registers have an issued-but-not-yet-committed write.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   alu_valid/alu_ready        ALU result handshake
//   alu_rd/alu_data            ALU destination register and value
//   mem_valid/mem_ready        load result handshake
//   mem_rd/mem_data            load destination register and value
//   issue_valid/issue_rd       decode wants to issue a writer of issue_rd
//   issue_ready                no write-after-write hazard on issue_rd
//   q_a1/q_a2                  source registers queried by decode
//   q_busy1/q_busy2            queried register has a write pending
//   we3/a3/wd3                 registered register file write port
module regfile_wb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3
);

    typedef enum logic {
        GRANT_ALU,
        GRANT_MEM
    } grant_t;

    grant_t      r_last_grant;
    logic        r_we3;
    logic [4:0]  r_a3;
    logic [31:0] r_wd3;
    logic [31:1] r_pending;

    logic        w_pick_alu;
    logic        w_pick_mem;
    logic        w_xfer;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic [31:0] w_pending;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_pending_next;

    // Bit 0 of the scoreboard is hard-wired low so x0 never looks busy.
    assign w_pending = {r_pending, 1'b0};

    // ALU wins unless MEM is also valid and ALU was the last one served.
    assign w_pick_alu = alu_valid & (~mem_valid | (r_last_grant == GRANT_MEM));
    assign w_pick_mem = mem_valid & ~w_pick_alu;

    assign alu_ready = rst_n & w_pick_alu;
    assign mem_ready = rst_n & w_pick_mem;
    assign w_xfer    = alu_ready | mem_ready;
    assign w_rd      = alu_ready ? alu_rd   : mem_rd;
    assign w_data    = alu_ready ? alu_data : mem_data;

    assign issue_ready = ~rst_n | ~w_pending[issue_rd];
    assign q_busy1     = rst_n & w_pending[q_a1];
    assign q_busy2     = rst_n & w_pending[q_a2];

    // Clear is applied before set so a same-edge commit and re-issue of
    // one register leaves it pending.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && issue_ready && (issue_rd != 5'd0))
            w_set = 32'd1 << issue_rd;
        if (r_we3)
            w_clr = 32'd1 << r_a3;
        w_pending_next = (w_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_MEM;
            r_we3        <= 1'b0;
            r_a3         <= '0;
            r_wd3        <= '0;
            r_pending    <= '0;
        end else begin
            r_we3     <= w_xfer && (w_rd != 5'd0);
            r_pending <= w_pending_next[31:1];
            if (w_xfer) begin
                r_a3         <= w_rd;
                r_wd3        <= w_data;
                r_last_grant <= alu_ready ? GRANT_ALU : GRANT_MEM;
            end
        end
    end

    assign we3 = r_we3;
    assign a3  = r_a3;
    assign wd3 = r_wd3;

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, mem_valid, issue_valid;
    logic        alu_ready, mem_ready, issue_ready;
    logic [4:0]  alu_rd, mem_rd, issue_rd, q_a1, q_a2, a3;
    logic [31:0] alu_data, mem_data, wd3;
    logic        q_busy1, q_busy2, we3;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wb dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .we3(we3), .a3(a3), .wd3(wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: set of registers with a pending write, the write
    // expected on the port this cycle, and who was served last.
    bit          m_pend [32];
    bit          m_we       = 1'b0;
    logic [4:0]  m_a3       = '0;
    logic [31:0] m_wd3      = '0;
    bit          m_last_alu = 1'b0;

    // 0 = nobody, 1 = ALU, 2 = MEM
    function automatic int grant();
        if (alu_valid && mem_valid) return m_last_alu ? 2 : 1;
        if (alu_valid) return 1;
        if (mem_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        int  g;
        bit  iss;
        if (!rst_n) begin
            foreach (m_pend[k]) m_pend[k] = 1'b0;
            m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_last_alu = 1'b0;
        end else begin
            g   = grant();
            iss = issue_valid && (issue_rd != 0) && !m_pend[issue_rd];
            if (m_we) m_pend[m_a3] = 1'b0;
            if (iss)  m_pend[issue_rd] = 1'b1;
            m_we = 1'b0;
            if (g == 1) begin
                m_last_alu = 1'b1;
                if (alu_rd != 0) begin m_we = 1'b1; m_a3 = alu_rd; m_wd3 = alu_data; end
            end else if (g == 2) begin
                m_last_alu = 1'b0;
                if (mem_rd != 0) begin m_we = 1'b1; m_a3 = mem_rd; m_wd3 = mem_data; end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        if (!rst_n) begin
            chk("alu_ready_rst", alu_ready, 0);
            chk("mem_ready_rst", mem_ready, 0);
            chk("issue_ready_rst", issue_ready, 1);
            chk("q_busy1_rst", q_busy1, 0);
            chk("q_busy2_rst", q_busy2, 0);
        end else begin
            g = grant();
            chk("alu_ready", alu_ready, (g == 1) ? 1 : 0);
            chk("mem_ready", mem_ready, (g == 2) ? 1 : 0);
            chk("issue_ready", issue_ready, m_pend[issue_rd] ? 0 : 1);
            chk("q_busy1", q_busy1, m_pend[q_a1] ? 1 : 0);
            chk("q_busy2", q_busy2, m_pend[q_a2] ? 1 : 0);
        end
        chk("we3", we3, m_we ? 1 : 0);
        if (m_we) begin
            chk("a3", a3, m_a3);
            chk("wd3", wd3, m_wd3);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  exp_a3 [4];
    logic [31:0] exp_wd [4];

    initial begin
        exp_a3 = '{5'd1, 5'd2, 5'd1, 5'd2};
        exp_wd = '{32'd10, 32'd21, 32'd12, 32'd23};
        rst_n = 1'b0;
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        alu_rd = 0; mem_rd = 0; issue_rd = 0; q_a1 = 0; q_a2 = 0;
        alu_data = 0; mem_data = 0;
        repeat (3) cyc();
        @(negedge clk);
        chk("lit_rst_we3", we3, 0);
        chk("lit_rst_a3", a3, 0);
        chk("lit_rst_wd3", wd3, 0);
        chk("lit_rst_issue_ready", issue_ready, 1);
        cyc(); rst_n = 1'b1;

        // single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 42;
        cyc(); alu_valid = 0;
        @(negedge clk);
        chk("lit_single_we3", we3, 1);
        chk("lit_single_a3", a3, 5);
        chk("lit_single_wd3", wd3, 42);
        cyc(); @(negedge clk);
        chk("lit_single_we3_off", we3, 0);

        // contention after reset: ALU first, then alternate
        rst_n = 0; cyc(); rst_n = 1;
        alu_valid = 1; mem_valid = 1; alu_rd = 1; mem_rd = 2;
        for (int i = 0; i < 4; i++) begin
            alu_data = 10 + i; mem_data = 20 + i;
            cyc(); @(negedge clk);
            chk("lit_rr_we3", we3, 1);
            chk("lit_rr_a3", a3, exp_a3[i]);
            chk("lit_rr_wd3", wd3, exp_wd[i]);
        end
        alu_valid = 0; mem_valid = 0;

        // scoreboard set then clear by commit
        cyc(); issue_valid = 1; issue_rd = 7; q_a1 = 7;
        cyc(); issue_valid = 0;
        @(negedge clk);
        chk("lit_sb_busy", q_busy1, 1);
        chk("lit_sb_issue_ready", issue_ready, 0);
        mem_valid = 1; mem_rd = 7; mem_data = 77;
        cyc(); mem_valid = 0;
        @(negedge clk);
        chk("lit_sb_busy_wb", q_busy1, 1);
        chk("lit_sb_a3", a3, 7);
        cyc(); @(negedge clk);
        chk("lit_sb_busy_clr", q_busy1, 0);

        // x0 handling
        cyc(); alu_valid = 1; alu_rd = 0; alu_data = 122;
        @(negedge clk);
        chk("lit_x0_ready", alu_ready, 1);
        cyc(); alu_valid = 0;
        @(negedge clk);
        chk("lit_x0_we3", we3, 0);
        issue_valid = 1; issue_rd = 0; q_a1 = 0;
        cyc(); issue_valid = 0;
        @(negedge clk);
        chk("lit_x0_busy", q_busy1, 0);
        chk("lit_x0_issue_ready", issue_ready, 1);

        // same-edge commit and re-issue of x3
        cyc(); alu_valid = 1; alu_rd = 3; alu_data = 33;
        cyc(); alu_valid = 0; issue_valid = 1; issue_rd = 3; q_a2 = 3;
        @(negedge clk);
        chk("lit_same_we3", we3, 1);
        chk("lit_same_issue_ready", issue_ready, 1);
        cyc(); issue_valid = 0;
        @(negedge clk);
        chk("lit_same_busy", q_busy2, 1);

        // reset in the middle of traffic
        cyc(); issue_valid = 1; issue_rd = 9; q_a1 = 9;
        cyc(); issue_valid = 0; alu_valid = 1; alu_rd = 4; alu_data = 44;
        cyc(); alu_valid = 0; rst_n = 0; mem_valid = 1; mem_rd = 6; mem_data = 66;
        @(negedge clk);
        chk("lit_mid_rst_mem_ready", mem_ready, 0);
        cyc(); rst_n = 1; mem_valid = 0;
        @(negedge clk);
        chk("lit_mid_we3", we3, 0);
        chk("lit_mid_busy1", q_busy1, 0);
        chk("lit_mid_busy2", q_busy2, 0);
        alu_valid = 1; mem_valid = 1; alu_rd = 10; mem_rd = 11; alu_data = 100; mem_data = 110;
        cyc(); alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        chk("lit_mid_grant_alu", a3, 10);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst_n       = ($urandom_range(0, 99) != 0);
            alu_valid   = $urandom_range(0, 1);
            mem_valid   = $urandom_range(0, 1);
            issue_valid = $urandom_range(0, 1);
            alu_rd      = $urandom_range(0, 7);
            mem_rd      = $urandom_range(0, 7);
            issue_rd    = $urandom_range(0, 7);
            q_a1        = $urandom_range(0, 7);
            q_a2        = $urandom_range(0, 31);
            alu_data    = $urandom;
            mem_data    = $urandom;
        end
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
